// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/grant/response bus between the LSU and memory
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: lane alignment, load extension, misalign and timeout
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        lb,
  input  logic        lh,
  input  logic        lbu,
  input  logic        lhu,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_q, byte_d, half_q, half_d, uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic             req_d, we_d;
  logic [31:0]      maddr_d, mwdata_d;
  logic [3:0]       wmask_d;
  logic             done_d, misalign_d, bus_err_d;
  logic [31:0]      rdata_d;
  logic             start, is_half, is_word, misaligned, last;
  logic [31:0]      ld_ext;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic b, input logic h, input logic u);
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] res;
    case (off)
      2'd0:    bv = w[7:0];
      2'd1:    bv = w[15:8];
      2'd2:    bv = w[23:16];
      default: bv = w[31:24];
    endcase
    hv = off[1] ? w[31:16] : w[15:0];
    if (b)      res = u ? {24'b0, bv} : {{24{bv[7]}}, bv};
    else if (h) res = u ? {16'b0, hv} : {{16{hv[15]}}, hv};
    else        res = w;
    return res;
  endfunction

  assign start      = acc_valid & (memread | memwrite);
  assign is_half    = ~lb & lh;
  assign is_word    = ~lb & ~lh;
  assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  // Last permitted REQ/WAIT cycle: the access has now spent TIMEOUT cycles on the bus.
  assign last       = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign ld_ext     = extend(bus.mem_rdata, off_q, byte_q, half_q, uns_q);
  assign stall      = ((state_q == IDLE) & start) | (state_q == REQ) | (state_q == WAIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    half_d     = half_q;
    uns_d      = uns_q;
    off_d      = off_q;
    req_d      = 1'b0;
    we_d       = bus.mem_we;
    maddr_d    = bus.mem_addr;
    wmask_d    = bus.mem_wmask;
    mwdata_d   = bus.mem_wdata;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    rdata_d    = 32'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          byte_d = lb;
          half_d = is_half;
          uns_d  = lb ? lbu : lhu;
          off_d  = addr[1:0];
          if (misaligned) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = memwrite;
            maddr_d = {addr[31:2], 2'b00};
            if (!memwrite) begin
              wmask_d  = 4'b0000;
              mwdata_d = 32'b0;
            end else if (lb) begin
              wmask_d  = 4'b0001 << addr[1:0];
              mwdata_d = {4{wdata[7:0]}};
            end else if (lh) begin
              wmask_d  = addr[1] ? 4'b1100 : 4'b0011;
              mwdata_d = {2{wdata[15:0]}};
            end else begin
              wmask_d  = 4'b1111;
              mwdata_d = wdata;
            end
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_gnt && bus.mem_we) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (bus.mem_gnt && bus.mem_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = ld_ext;
        end else if (last) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else if (bus.mem_gnt) begin
          state_d = WAIT;
        end else begin
          req_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_rvalid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = ld_ext;
        end else if (last) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      uns_q         <= 1'b0;
      off_q         <= 2'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'b0;
      bus.mem_wmask <= 4'b0;
      bus.mem_wdata <= 32'b0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
      rdata         <= 32'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      half_q        <= half_d;
      uns_q         <= uns_d;
      off_q         <= off_d;
      bus.mem_req   <= req_d;
      bus.mem_we    <= we_d;
      bus.mem_addr  <= maddr_d;
      bus.mem_wmask <= wmask_d;
      bus.mem_wdata <= mwdata_d;
      done          <= done_d;
      misalign      <= misalign_d;
      bus_err       <= bus_err_d;
      rdata         <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against an arithmetic model
module tb_load_store_unit;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_valid, memread, memwrite;
  logic [31:0] addr, wdata;
  logic        lb, lh, lbu, lhu;
  logic        stall, done, misalign, bus_err;
  logic [31:0] rdata;
  int          vectors = 0;
  int          miscompares = 0;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .acc_valid(acc_valid), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .lb(lb), .lh(lh), .lbu(lbu), .lhu(lhu),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    acc_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
  endtask

  // sz: 0 byte, 1 half, 2 word. Starts and ends #1 after a rising edge with the unit idle.
  task automatic run_access(input bit w, input int sz, input bit uns, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rw, input int gdly, input int rdly);
    logic [31:0] e_addr, e_wdata, e_rdata, sh;
    logic [3:0]  e_mask;
    int          off, k, gk;
    bit          mis, granted, seen;
    off     = a % 4;
    mis     = (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
    e_addr  = a - off;
    e_wdata = (sz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
              (sz == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    e_mask  = !w ? 4'd0 : (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'd15;
    sh      = rw >> (8 * off);
    if (sz == 0) begin
      e_rdata = sh & 32'hFF;
      if (!uns && e_rdata >= 128) e_rdata = e_rdata | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      e_rdata = sh & 32'hFFFF;
      if (!uns && e_rdata >= 32768) e_rdata = e_rdata | 32'hFFFF_0000;
    end else begin
      e_rdata = rw;
    end
    if (w || mis) e_rdata = 32'h0;

    acc_valid = 1'b1;
    memwrite  = w;
    memread   = w ? 1'($urandom_range(0, 1)) : 1'b1;
    addr = a; wdata = wd;
    lb = (sz == 0); lh = (sz == 1);
    lbu = (sz == 0) && uns; lhu = (sz == 1) && uns;
    #1 chk("stall_on_request", stall, 1);

    granted = 0; seen = 0; gk = 0; k = 0;
    while (!seen && k < TIMEOUT + 4) begin
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (done) begin
        seen = 1;
      end else if (!granted) begin
        chk("mem_req_held", bus.mem_req, 1);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_we", bus.mem_we, w);
        chk("mem_wmask", bus.mem_wmask, e_mask);
        if (w) chk("mem_wdata", bus.mem_wdata, e_wdata);
        if (k == gdly) begin
          bus.mem_gnt = 1'b1; granted = 1; gk = k;
          if (!w && rdly == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rw; end
        end
      end else begin
        chk("mem_req_dropped_wait", bus.mem_req, 0);
        if (k == gk + rdly) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rw; end
      end
      k++;
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("done_seen", seen, 1);
    chk("misalign", misalign, mis);
    chk("bus_err", bus_err, 0);
    chk("rdata", rdata, e_rdata);
    chk("stall_in_done", stall, 0);
    chk("mem_req_at_done", bus.mem_req, 0);
    clear_acc();
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_timeout(input bit give_gnt, input logic [31:0] a);
    int n;
    bit seen;
    acc_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = a;
    lb = 1'b0; lh = 1'b0; lbu = 1'b0; lhu = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < TIMEOUT + 10) begin
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      if (done) begin
        seen = 1;
      end else begin
        if (n == 0) chk("timeout_req_start", bus.mem_req, 1);
        if (give_gnt && n == 0) bus.mem_gnt = 1'b1;
        n++;
      end
    end
    chk("timeout_done_seen", seen, 1);
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_rdata", rdata, 0);
    chk("timeout_misalign", misalign, 0);
    chk("timeout_mem_req", bus.mem_req, 0);
    clear_acc();
    repeat (3) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
      @(posedge clk); #1;
      chk("stray_rvalid_done", done, 0);
      chk("stray_rvalid_stall", stall, 0);
    end
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    int          sz, gd, rd;
    bit          w, u;
    logic [31:0] a;

    reset = 1'b1;
    clear_acc();
    addr = 32'h0; wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_access(0, 0, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1);
    run_access(0, 1, 1, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 2);
    run_access(0, 1, 0, 32'h0000_0102, 32'h0, 32'h8001_0000, 1, 0);
    run_access(1, 1, 0, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 3, 0);
    run_access(1, 0, 0, 32'h0000_0301, 32'h1234_56A5, 32'h0, 0, 0);
    run_access(0, 2, 0, 32'h0000_0101, 32'h0, 32'h1111_2222, 0, 0);
    run_access(1, 1, 0, 32'h0000_0205, 32'hCAFE_F00D, 32'h0, 0, 0);

    run_timeout(1, 32'h0000_0400);
    run_timeout(0, 32'h0000_0404);

    // Reset landing while a read is waiting for data.
    acc_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; addr = 32'h0000_0300;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    chk("wait_stall", stall, 1);
    chk("wait_mem_req", bus.mem_req, 0);
    reset = 1'b1;
    clear_acc();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstwait_stall", stall, 0);
    chk("rstwait_done", done, 0);
    chk("rstwait_mem_req", bus.mem_req, 0);
    chk("rstwait_mem_addr", bus.mem_addr, 0);
    chk("rstwait_rdata", rdata, 0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    chk("rstwait_late_rvalid", done, 0);
    @(posedge clk); #1;
    chk("rstwait_late_rvalid2", done, 0);

    for (int i = 0; i < 60; i++) begin
      sz = $urandom_range(0, 2);
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ((sz == 0) ? 32'hFFFF_FFFF : (sz == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
      gd = $urandom_range(0, 4);
      rd = $urandom_range(0, 4);
      run_access(w, sz, u, a, $urandom, $urandom, gd, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
